id_ex_stage: RTL

ID/EX pipeline register for the 5-stage WISC-SP22 pipeline. It latches decoded ID-stage control, register selects and operands, and presents them to the EX-stage forwarding logic and the ALU. It also owns load-use hazard detection: it inserts a one-cycle bubble and requests an IF/ID hold when needed. It handles flush on branch/jump redirect, holds on downstream memory stall, and latches HALT.

---
 rtl/wisc_pkg.sv | 36 +++
 rtl/id_ex_stage_if.sv | 86 ++++++++
 rtl/id_ex_stage_load_use_detect.sv | 30 +++
 rtl/id_ex_stage.sv | 94 +++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC-SP22 pipeline types and constants.
// Holds opcode values and the ID/EX bundle with its bubble value.
package wisc_pkg;

  localparam int OP_W   = 5;
  localparam int REG_AW = 3;
  localparam int DATA_W = 16;

  localparam logic [OP_W-1:0] OP_HALT = 5'b00000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b00001;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] wr;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              link;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc2;
  } id_ex_t;

  // NOP opcode keeps forwarding logic from matching a bubble
  localparam id_ex_t BUBBLE = '{
    1'b0, OP_NOP, '0, '0, '0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    '0, '0, '0, '0
  };

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bundle: decoded ID fields in, registered EX fields out.
// master drives the ID side, slave is the pipeline register.
interface id_ex_stage_if
  import wisc_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic              valid_id;
  logic [OP_W-1:0]   OpCode_id;
  logic [REG_AW-1:0] read1RegSel_id;
  logic [REG_AW-1:0] read2RegSel_id;
  logic              rs1_used_id;
  logic              rs2_used_id;
  logic [REG_AW-1:0] Write_register_id;
  logic              RegWrite_id;
  logic              MemRead_id;
  logic              MemWrite_id;
  logic              MemtoReg_id;
  logic              link_id;
  logic [DATA_W-1:0] read1Data_id;
  logic [DATA_W-1:0] read2Data_id;
  logic [DATA_W-1:0] imm_id;
  logic [DATA_W-1:0] pc2_id;
  logic              flush;
  logic              stall_mem;

  logic              valid_ex;
  logic [OP_W-1:0]   OpCode_EX;
  logic [REG_AW-1:0] read1RegSel_EX;
  logic [REG_AW-1:0] read2RegSel_EX;
  logic [REG_AW-1:0] Write_register_EX;
  logic              RegWrite_EX;
  logic              MemRead_EX;
  logic              MemWrite_EX;
  logic              MemtoReg_EX;
  logic              link_EX;
  logic [DATA_W-1:0] read1Data_EX;
  logic [DATA_W-1:0] read2Data_EX;
  logic [DATA_W-1:0] imm_EX;
  logic [DATA_W-1:0] pc2_EX;
  logic              stall_id;
  logic              halted;
  logic [CNT_W-1:0]  lu_stall_cnt;

  modport master (
    output valid_id, OpCode_id,
    output read1RegSel_id, read2RegSel_id,
    output rs1_used_id, rs2_used_id,
    output Write_register_id,
    output RegWrite_id, MemRead_id,
    output MemWrite_id, MemtoReg_id, link_id,
    output read1Data_id, read2Data_id,
    output imm_id, pc2_id,
    output flush, stall_mem,
    input  valid_ex, OpCode_EX,
    input  read1RegSel_EX, read2RegSel_EX,
    input  Write_register_EX,
    input  RegWrite_EX, MemRead_EX,
    input  MemWrite_EX, MemtoReg_EX, link_EX,
    input  read1Data_EX, read2Data_EX,
    input  imm_EX, pc2_EX,
    input  stall_id, halted, lu_stall_cnt
  );

  modport slave (
    input  valid_id, OpCode_id,
    input  read1RegSel_id, read2RegSel_id,
    input  rs1_used_id, rs2_used_id,
    input  Write_register_id,
    input  RegWrite_id, MemRead_id,
    input  MemWrite_id, MemtoReg_id, link_id,
    input  read1Data_id, read2Data_id,
    input  imm_id, pc2_id,
    input  flush, stall_mem,
    output valid_ex, OpCode_EX,
    output read1RegSel_EX, read2RegSel_EX,
    output Write_register_EX,
    output RegWrite_EX, MemRead_EX,
    output MemWrite_EX, MemtoReg_EX, link_EX,
    output read1Data_EX, read2Data_EX,
    output imm_EX, pc2_EX,
    output stall_id, halted, lu_stall_cnt
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard compare between a load in EX and the ID sources.
// Pure combinational; shared with the MEM-stage stall unit.
module load_use_detect
  import wisc_pkg::*;
(
  input  logic              i_valid_ex,
  input  logic              i_memread_ex,
  input  logic              i_regwrite_ex,
  input  logic [REG_AW-1:0] i_wr_ex,
  input  logic              i_valid_id,
  input  logic              i_flush,
  input  logic              i_rs1_used,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic              i_rs2_used,
  input  logic [REG_AW-1:0] i_rs2,
  output logic              o_load_use
);

  logic w_ld_ex;
  logic w_hit1;
  logic w_hit2;

  assign w_ld_ex = i_valid_ex & i_memread_ex & i_regwrite_ex;
  assign w_hit1  = i_rs1_used & (i_rs1 == i_wr_ex);
  assign w_hit2  = i_rs2_used & (i_rs2 == i_wr_ex);

  assign o_load_use = w_ld_ex & i_valid_id & ~i_flush
                    & (w_hit1 | w_hit2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// flush, memory-stall hold and sticky HALT latch.
module id_ex_stage
  import wisc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic    clk,
  input logic    rst_n,
  id_ex_stage_if.slave bus
);

  id_ex_t           r_ex;
  logic             r_halted;
  logic [CNT_W-1:0] r_cnt;

  id_ex_t w_cap;
  logic   w_load_use;
  logic   w_is_halt;

  load_use_detect u_lud (
    .i_valid_ex   (r_ex.valid),
    .i_memread_ex (r_ex.memread),
    .i_regwrite_ex(r_ex.regwrite),
    .i_wr_ex      (r_ex.wr),
    .i_valid_id   (bus.valid_id),
    .i_flush      (bus.flush),
    .i_rs1_used   (bus.rs1_used_id),
    .i_rs1        (bus.read1RegSel_id),
    .i_rs2_used   (bus.rs2_used_id),
    .i_rs2        (bus.read2RegSel_id),
    .o_load_use   (w_load_use)
  );

  // write-type controls are masked so an empty ID slot never commits
  assign w_cap = '{
    bus.valid_id,
    bus.OpCode_id,
    bus.read1RegSel_id,
    bus.read2RegSel_id,
    bus.Write_register_id,
    bus.RegWrite_id & bus.valid_id,
    bus.MemRead_id  & bus.valid_id,
    bus.MemWrite_id & bus.valid_id,
    bus.MemtoReg_id,
    bus.link_id     & bus.valid_id,
    bus.read1Data_id,
    bus.read2Data_id,
    bus.imm_id,
    bus.pc2_id
  };

  assign w_is_halt = bus.valid_id
                   & (bus.OpCode_id == OP_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex     <= BUBBLE;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else if (!bus.stall_mem) begin
      if (r_halted || bus.flush) begin
        r_ex <= BUBBLE;
      end else if (w_load_use) begin
        r_ex <= BUBBLE;
        if (r_cnt != '1)
          r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_ex <= w_cap;
        if (w_is_halt)
          r_halted <= 1'b1;
      end
    end
  end

  assign bus.stall_id          = bus.stall_mem | w_load_use;
  assign bus.valid_ex          = r_ex.valid;
  assign bus.OpCode_EX         = r_ex.op;
  assign bus.read1RegSel_EX    = r_ex.rs1;
  assign bus.read2RegSel_EX    = r_ex.rs2;
  assign bus.Write_register_EX = r_ex.wr;
  assign bus.RegWrite_EX       = r_ex.regwrite;
  assign bus.MemRead_EX        = r_ex.memread;
  assign bus.MemWrite_EX       = r_ex.memwrite;
  assign bus.MemtoReg_EX       = r_ex.memtoreg;
  assign bus.link_EX           = r_ex.link;
  assign bus.read1Data_EX      = r_ex.d1;
  assign bus.read2Data_EX      = r_ex.d2;
  assign bus.imm_EX            = r_ex.imm;
  assign bus.pc2_EX            = r_ex.pc2;
  assign bus.halted            = r_halted;
  assign bus.lu_stall_cnt      = r_cnt;

endmodule
